// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the banked register file.
//   - mode_e    : processor mode encodings (M field)
//   - PHYS_*    : physical register indices after bank mapping
//   - NUM_PHYS  : physical registers including the PC
//   - NUM_GPR   : general (non-PC) physical registers
package regfile_pkg;

  typedef enum logic [4:0] {
    MODE_USR = 5'b10000,
    MODE_FIQ = 5'b10001,
    MODE_IRQ = 5'b10010,
    MODE_SVC = 5'b10011,
    MODE_ABT = 5'b10111,
    MODE_UND = 5'b11011,
    MODE_SYS = 5'b11111
  } mode_e;

  // Physical layout: 0-7 shared, 8-12 usr r8-r12, 13-17 fiq r8-r12,
  // 18-29 r13/r14 pairs per mode, 30 is the PC.
  localparam logic [4:0] PHYS_R8_USR  = 5'd8;
  localparam logic [4:0] PHYS_R8_FIQ  = 5'd13;
  localparam logic [4:0] PHYS_R13_USR = 5'd18;
  localparam logic [4:0] PHYS_R13_FIQ = 5'd20;
  localparam logic [4:0] PHYS_R13_IRQ = 5'd22;
  localparam logic [4:0] PHYS_R13_SVC = 5'd24;
  localparam logic [4:0] PHYS_R13_ABT = 5'd26;
  localparam logic [4:0] PHYS_R13_UND = 5'd28;
  localparam logic [4:0] PHYS_PC      = 5'd30;

  localparam int unsigned NUM_PHYS = 31;
  localparam int unsigned NUM_GPR  = 30;

endpackage

// File: rtl/bank_map.sv
// bank_map: combinational map from (mode, architectural address) to the
// physical register index.
//   m       in  5   processor mode
//   addr    in  AW  architectural register address (15 = PC)
//   phys    out 5   physical register index
//   illegal out 1   m is not a recognised mode (usr bank is used)
module bank_map
  import regfile_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic [4:0]    m,
  input  logic [AW-1:0] addr,
  output logic [4:0]    phys,
  output logic          illegal
);

  logic       is_fiq;
  logic [4:0] base13;

  always_comb begin
    illegal = 1'b0;
    is_fiq  = 1'b0;
    base13  = PHYS_R13_USR;
    case (m)
      MODE_USR, MODE_SYS: ;
      MODE_FIQ: begin is_fiq = 1'b1; base13 = PHYS_R13_FIQ; end
      MODE_IRQ: base13 = PHYS_R13_IRQ;
      MODE_SVC: base13 = PHYS_R13_SVC;
      MODE_ABT: base13 = PHYS_R13_ABT;
      MODE_UND: base13 = PHYS_R13_UND;
      default:  illegal = 1'b1;
    endcase

    if (addr == AW'(15))
      phys = PHYS_PC;
    else if (addr >= AW'(13))
      phys = base13 + 5'(addr - AW'(13));
    else if (addr >= AW'(8) && is_fiq)
      phys = PHYS_R8_FIQ + 5'(addr - AW'(8));
    else
      phys = 5'(addr);
  end

endmodule

// File: rtl/banked_regfile_mp.sv
// banked_regfile_mp: mode-banked register file with NRD combinational read
// ports, one write port and a dedicated PC with load/auto-increment.
//   clk       in  1       clock
//   rst       in  1       asynchronous active-low reset
//   r_addr    in  NRD*AW  packed read addresses (port k at [k*AW +: AW])
//   r_data    out NRD*DW  packed read data (port k at [k*DW +: DW])
//   w_addr    in  AW      write address
//   w_data    in  DW      write data
//   write_reg in  1       register write enable
//   write_pc  in  1       PC load enable
//   pc_data   in  DW      PC load value
//   pc_inc    in  1       PC increment enable
//   M         in  5       processor mode
//   pc_out    out DW      stored PC
//   mode_err  out 1       sticky illegal-mode flag
module banked_regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = 32,
  parameter int NRD      = 3,
  parameter int AW       = 4,
  parameter int PC_STEP  = 4,
  parameter int RESET_PC = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] r_addr,
  output logic [NRD*DW-1:0] r_data,
  input  logic [AW-1:0]     w_addr,
  input  logic [DW-1:0]     w_data,
  input  logic              write_reg,
  input  logic              write_pc,
  input  logic [DW-1:0]     pc_data,
  input  logic              pc_inc,
  input  logic [4:0]        M,
  output logic [DW-1:0]     pc_out,
  output logic              mode_err
);

  localparam logic [AW-1:0] PC_ADDR = AW'(15);

  logic [DW-1:0]  regs [NUM_GPR];
  logic [DW-1:0]  pc;

  logic [4:0]     wr_phys;
  logic           wr_illegal;
  logic [NRD-1:0] rd_illegal;

  logic           gpr_we;
  logic           pc_load;
  logic [DW-1:0]  pc_load_val;
  logic [DW-1:0]  pc_next;

  bank_map #(.AW(AW)) u_wr_map (
    .m       (M),
    .addr    (w_addr),
    .phys    (wr_phys),
    .illegal (wr_illegal)
  );

  // write_pc outranks a write_reg to r15, which outranks pc_inc.
  always_comb begin
    gpr_we      = write_reg && (w_addr != PC_ADDR);
    pc_load     = write_pc || (write_reg && (w_addr == PC_ADDR));
    pc_load_val = write_pc ? pc_data : w_data;
    if (pc_load)
      pc_next = pc_load_val;
    else if (pc_inc)
      pc_next = pc + DW'(PC_STEP);
    else
      pc_next = pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_GPR; i++)
        regs[i] <= '0;
      pc       <= DW'(RESET_PC);
      mode_err <= 1'b0;
    end else begin
      if (gpr_we)
        regs[wr_phys] <= w_data;
      pc <= pc_next;
      if (wr_illegal || (|rd_illegal))
        mode_err <= 1'b1;
    end
  end

  assign pc_out = pc;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic [4:0]    phys;
    logic [DW-1:0] val;
    logic          wr_hit;

    assign addr = r_addr[k*AW +: AW];

    bank_map #(.AW(AW)) u_rd_map (
      .m       (M),
      .addr    (addr),
      .phys    (phys),
      .illegal (rd_illegal[k])
    );

    // Physical-index compare so a write only forwards to a read of the
    // same bank copy; pc_inc alone is deliberately not forwarded.
    always_comb begin
      wr_hit = gpr_we && (addr != PC_ADDR) && (phys == wr_phys);
      if (addr == PC_ADDR)
        val = (BYPASS != 0 && pc_load) ? pc_load_val : pc;
      else if (BYPASS != 0 && wr_hit)
        val = w_data;
      else
        val = regs[phys];
    end

    assign r_data[k*DW +: DW] = val;
  end

endmodule

// File: tb/tb_banked_regfile_mp.sv
module tb_banked_regfile_mp;

  localparam int DW  = 32;
  localparam int NRD = 3;
  localparam int AW  = 4;

  localparam logic [4:0] USR = 5'b10000;
  localparam logic [4:0] FIQ = 5'b10001;
  localparam logic [4:0] IRQ = 5'b10010;
  localparam logic [4:0] SVC = 5'b10011;
  localparam logic [4:0] SYS = 5'b11111;
  localparam logic [4:0] BAD = 5'b10100;

  logic              clk = 1'b0;
  logic              rst;
  logic [NRD*AW-1:0] r_addr;
  logic [NRD*DW-1:0] r_data, r_data_nb;
  logic [AW-1:0]     w_addr;
  logic [DW-1:0]     w_data;
  logic              write_reg, write_pc, pc_inc;
  logic [DW-1:0]     pc_data;
  logic [4:0]        M;
  logic [DW-1:0]     pc_out, pc_out_nb;
  logic              mode_err, mode_err_nb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  banked_regfile_mp #(.DW(DW), .NRD(NRD), .AW(AW), .PC_STEP(4),
                      .RESET_PC(0), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .r_addr(r_addr), .r_data(r_data),
    .w_addr(w_addr), .w_data(w_data), .write_reg(write_reg),
    .write_pc(write_pc), .pc_data(pc_data), .pc_inc(pc_inc), .M(M),
    .pc_out(pc_out), .mode_err(mode_err)
  );

  banked_regfile_mp #(.DW(DW), .NRD(NRD), .AW(AW), .PC_STEP(4),
                      .RESET_PC(0), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .r_addr(r_addr), .r_data(r_data_nb),
    .w_addr(w_addr), .w_data(w_data), .write_reg(write_reg),
    .write_pc(write_pc), .pc_data(pc_data), .pc_inc(pc_inc), .M(M),
    .pc_out(pc_out_nb), .mode_err(mode_err_nb)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return r_data[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rd_nb(input int k);
    return r_data_nb[k*DW +: DW];
  endfunction

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    r_addr[k*AW +: AW] = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_reg = 1'b1; w_addr = a; w_data = d;
    step();
    write_reg = 1'b0;
  endtask

  initial begin
    rst = 1'b0; r_addr = '0; w_addr = '0; w_data = '0;
    write_reg = 1'b0; write_pc = 1'b0; pc_data = '0; pc_inc = 1'b0; M = USR;
    #2;
    check("reset_pc", pc_out, 32'h0);
    check("reset_err", {31'b0, mode_err}, 32'h0);
    check("reset_rd0", rd(0), 32'h0);
    #1 rst = 1'b1;
    step();

    // Banking of r13 and r8
    M = USR; wr(4'd13, 32'hAAAA0001);
    M = SVC; wr(4'd13, 32'hBBBB0002);
    set_ra(0, 4'd13);
    #1 check("svc_r13", rd(0), 32'hBBBB0002);
    M = USR;
    #1 check("usr_r13", rd(0), 32'hAAAA0001);
    M = SYS;
    #1 check("sys_r13", rd(0), 32'hAAAA0001);
    M = USR; wr(4'd8, 32'h11111111);
    M = FIQ; wr(4'd8, 32'h22222222);
    set_ra(0, 4'd8);
    #1 check("fiq_r8", rd(0), 32'h22222222);
    M = IRQ;
    #1 check("irq_r8", rd(0), 32'h11111111);

    // Same-cycle write bypass on r5
    M = USR; wr(4'd5, 32'h00000F0F);
    set_ra(1, 4'd5);
    write_reg = 1'b1; w_addr = 4'd5; w_data = 32'h00001234;
    #1;
    check("byp_r5", rd(1), 32'h00001234);
    check("nobyp_r5_old", rd_nb(1), 32'h00000F0F);
    step();
    write_reg = 1'b0;
    #1 check("nobyp_r5_new", rd_nb(1), 32'h00001234);

    // svc r13 write forwards to a read of svc r13
    M = SVC; set_ra(0, 4'd13);
    write_reg = 1'b1; w_addr = 4'd13; w_data = 32'hCCCC0003;
    #1 check("byp_svc_r13", rd(0), 32'hCCCC0003);
    step();
    write_reg = 1'b0;
    // fiq r8 write does not forward to a read of r7
    M = FIQ; set_ra(0, 4'd7);
    write_reg = 1'b1; w_addr = 4'd8; w_data = 32'h33333333;
    #1 check("nobyp_fiq_r7", rd(0), 32'h0);
    step();
    write_reg = 1'b0;

    // PC priority, bypass and wrap
    M = USR; set_ra(2, 4'd15);
    write_pc = 1'b1; pc_data = 32'h100;
    step();
    check("pc_load", pc_out, 32'h100);
    pc_data = 32'h200; write_reg = 1'b1; w_addr = 4'd15; w_data = 32'h300;
    pc_inc = 1'b1;
    #1;
    check("pc_byp", rd(2), 32'h200);
    check("pc_nobyp", rd_nb(2), 32'h100);
    check("pc_out_nobyp", pc_out, 32'h100);
    step();
    check("pc_prio1", pc_out, 32'h200);
    write_pc = 1'b0; write_reg = 1'b0;
    #1 check("pc_inc_nobyp", rd(2), 32'h200);
    step();
    check("pc_inc", pc_out, 32'h204);
    write_reg = 1'b1; w_addr = 4'd15; w_data = 32'h300;
    step();
    check("pc_prio2", pc_out, 32'h300);
    write_reg = 1'b0; pc_inc = 1'b0;
    write_pc = 1'b1; pc_data = 32'hFFFFFFFC;
    step();
    write_pc = 1'b0; pc_inc = 1'b1;
    step();
    pc_inc = 1'b0;
    check("pc_wrap", pc_out, 32'h0);
    step();
    check("pc_hold", pc_out, 32'h0);

    // Illegal mode is sticky and maps to the usr bank
    check("err_pre", {31'b0, mode_err}, 32'h0);
    M = BAD; wr(4'd9, 32'h55);
    check("err_set", {31'b0, mode_err}, 32'h1);
    M = USR; set_ra(0, 4'd9);
    #1 check("bad_usr_r9", rd(0), 32'h55);
    M = FIQ;
    #1 check("fiq_r9", rd(0), 32'h0);
    M = USR;
    step(); step();
    check("err_sticky", {31'b0, mode_err}, 32'h1);

    // Asynchronous reset away from any edge
    #2 rst = 1'b0;
    #1;
    check("arst_pc", pc_out, 32'h0);
    check("arst_err", {31'b0, mode_err}, 32'h0);
    check("arst_r9", rd(0), 32'h0);
    set_ra(0, 4'd13);
    #1 check("arst_r13", rd(0), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/banked_regfile_mp.md
Name: banked_regfile_mp

Overview:
Parametrised successor to the processor register file. Provides ARM-style mode-banked general registers, NRD combinational read ports and one write port. Holds a dedicated PC with load and auto-increment, optional same-cycle write-to-read bypass, and a sticky illegal-mode flag. Sits in the CPU datapath between decode (read addresses, mode M) and writeback (write port, PC update).

Parameters:
DW, 32, data width of every register
NRD, 3, number of read ports (1..4)
AW, 4, register address width (fixed 16 architectural registers; r15 = PC)
PC_STEP, 4, PC auto-increment amount
RESET_PC, 0, PC value after reset
BYPASS, 1, 1 = read ports forward same-cycle writes; 0 = reads show stored state only

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
r_addr  in  NRD*AW  packed read addresses, port k at bits [k*AW +: AW]
r_data  out  NRD*DW  packed read data, port k at bits [k*DW +: DW]
w_addr  in  AW  write address
w_data  in  DW  write data
write_reg  in  1  write enable for w_addr
write_pc  in  1  PC load enable
pc_data  in  DW  PC load value
pc_inc  in  1  PC increment enable
M  in  5  current processor mode
pc_out  out  DW  current PC register
mode_err  out  1  sticky: illegal M sampled during a write or read

Behaviour:
- Reset (rst=0, asynchronous): all 31 physical registers = 0; PC = RESET_PC; mode_err = 0. Release is synchronous to clk in the surrounding design.
- Mode encodings:
  - usr 10000, fiq 10001, irq 10010, svc 10011, abt 10111, und 11011, sys 11111.
  - sys uses the usr bank.
  - Any other M: usr bank, and mode_err sets on the next edge. mode_err clears only on reset.
- Banking, 31 physical registers:
  - r0-r7 shared by all modes.
  - r8-r12: usr bank, plus a separate fiq bank.
  - r13-r14: separate copies for usr, fiq, irq, svc, abt, und.
  - r15 = PC register (one).
- Reads:
  - Combinational, zero latency, selected by (M, r_addr[k]).
  - Address 15 returns the PC.
- Register write: on the edge with write_reg=1 and w_addr != 15, the bank selected by the current M is written. The mode is sampled in the same cycle as the write.
- PC next-value priority:
  1. write_pc -> pc_data
  2. write_reg with w_addr==15 -> w_data
  3. pc_inc -> PC + PC_STEP, modulo 2^DW (wrap, no flag)
  4. otherwise hold
- Simultaneous events:
  - write_pc together with write_reg to 15: pc_data wins; the w_data write is dropped.
  - write_reg to 15 together with pc_inc: w_data wins.
  - write_reg to r0-r14 proceeds in parallel with any PC update.
- Bypass (BYPASS=1), per read port:
  - write_reg=1, w_addr==r_addr[k]!=15 and both resolve to the same physical register: r_data shows w_data.
  - r_addr[k]==15 and PC is being loaded (priority 1 or 2): r_data shows the loaded value.
  - pc_inc alone is not bypassed.
  - With BYPASS=0, reads always show stored state.
- pc_out always shows the stored PC (never bypassed).
- Reset during a write: reset wins; no partial update.

Decomposition:
- Package regfile_pkg:
  - mode encoding constants (MODE_USR..MODE_SYS)
  - physical index constants (PHYS_R8_USR, PHYS_R8_FIQ, PHYS_R13_IRQ, ...)
  - NUM_PHYS = 31
- Sub-module bank_map: combinational map (M, addr) -> 5-bit physical index plus illegal-mode flag. One instance per read port and one for the write port.

Test Plan:
- Reset mid-run: rst low asynchronously -> pc_out=RESET_PC, every read returns 0, mode_err=0 with no clock edge.
- Banking: in usr write r13=0xAAAA0001; switch M=svc (10011), write r13=0xBBBB0002 -> svc read 0xBBBB0002, usr read 0xAAAA0001. In fiq, r8 is independent; in irq, r8 matches usr.
- PC priority: PC=0x100. write_pc=1/pc_data=0x200 with write_reg to 15 (0x300) and pc_inc -> PC=0x200. Next cycle pc_inc alone -> 0x204. PC=0xFFFFFFFC with pc_inc -> wraps to 0x0.
- Bypass: BYPASS=1, write r5=0x1234 while port1 reads r5 -> r_data port1=0x1234 the same cycle. Same test with BYPASS=0 -> old value, then 0x1234 after the edge.
- Bypass bank mismatch: in svc write r13 while reading r13 on another port -> bypass applies. In fiq, write r8 while reading r7 -> no bypass.
- Illegal mode: M=10100 with write r9=0x55 -> usr r9=0x55, mode_err=1 after the edge. Stays 1 with legal M until rst.
